des_sbox_engine: RTL and testbench

- Sequential DES substitution engine for the round function.
- Accepts one 48-bit expanded, key-mixed word and returns the 32-bit concatenation of S1..S8 outputs.
- Evaluates LANES S-boxes per cycle: LANES=8 is single-beat; smaller values trade latency for area.
- Sits between the E-expansion/key-XOR stage and the round's P-permutation/L-XOR stage, using valid/ready handshakes on both sides.

---
 rtl/des_sbox_pkg.sv | 61 ++++++
 rtl/des_sbox_lut.sv | 14 +
 rtl/des_sbox_engine.sv | 119 +++++++++++
 tb/tb_des_sbox_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_sbox_pkg.sv
// Shared DES S-box / P-permutation constants, engine FSM state type, lookup helpers.
// Combinational only: no latency, no handshake.
// S_ROWCOL holds the tables in standard row/column layout; S_TABLE is re-indexed by the raw 6-bit chunk.
package des_sbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index [box][row*16+col]; each 64-bit literal is one table row, column 0 leftmost.
    localparam logic [0:7][0:63][3:0] S_ROWCOL = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Row is {c[5],c[0]}, column is c[4:1], so row*16+col is just a bit shuffle of the chunk.
    function automatic logic [0:7][0:63][3:0] build_s_table();
        logic [0:7][0:63][3:0] t;
        logic [5:0]            c;
        t = '0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 64; i++) begin
                c       = 6'(i);
                t[b][i] = S_ROWCOL[b][{c[5], c[0], c[4:1]}];
            end
        end
        return t;
    endfunction

    localparam logic [0:7][0:63][3:0] S_TABLE = build_s_table();

    // Output bit i+1 takes input bit P_TABLE[i] (1-based DES numbering).
    localparam logic [0:31][5:0] P_TABLE = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box_idx, input logic [5:0] chunk);
        return S_TABLE[box_idx][chunk];
    endfunction

    function automatic logic [1:32] p_permute(input logic [1:32] x);
        logic [1:32] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            y[i+1] = x[P_TABLE[i]];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single DES S-box lookup: box_idx_i selects S1..S8 (0-based), chunk_i is the raw 6-bit input.
// Purely combinational, zero latency.
// No handshake; ports: box_idx_i[2:0], chunk_i[5:0] in, nibble_o[3:0] out.
module des_sbox_lut
    import des_sbox_pkg::*;
(
    input  logic [2:0] box_idx_i,
    input  logic [5:0] chunk_i,
    output logic [3:0] nibble_o
);

    assign nibble_o = sbox_lookup(box_idx_i, chunk_i);

endmodule

// File: rtl/des_sbox_engine.sv
// Sequential DES S-box stage: 48-bit expanded word in, 32-bit S1..S8 result out; LANES boxes per cycle.
// Latency BEATS=8/LANES cycles from accept to out_valid; minimum initiation interval BEATS+2.
// Backpressure: result held in DONE until out_ready; input refused outside IDLE. Define DES_SBOX_PPERM_EN to P-permute the output.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data[1:48]; out_valid/out_ready/out_data[1:32]; busy.
module des_sbox_engine
    import des_sbox_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_data,
    output logic        busy
);

    localparam int BEATS = 8 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [1:48]        word_q, word_d;
    logic [1:32]        result_q, result_d;
    logic [1:32]        merged;
    logic [1:32]        final_word;
    logic [2:0]         lane_box [LANES];
    logic [3:0]         lane_nib [LANES];

    // Lane i handles box beat*LANES+i during the current beat.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [5:0] chunk;
        assign lane_box[i] = 3'(int'(beat_q) * LANES + i);
        assign chunk       = word_q[6*int'(lane_box[i])+1 +: 6];
        des_sbox_lut u_lut (
            .box_idx_i (lane_box[i]),
            .chunk_i   (chunk),
            .nibble_o  (lane_nib[i])
        );
    end

    // Nibbles of boxes not evaluated this beat keep their previous value.
    always_comb begin
        merged = result_q;
        for (int i = 0; i < LANES; i++) begin
            merged[4*int'(lane_box[i])+1 +: 4] = lane_nib[i];
        end
    end

`ifdef DES_SBOX_PPERM_EN
    // The last beat completes the word, so permuting here overwrites all raw nibbles at once.
    assign final_word = p_permute(merged);
`else
    assign final_word = merged;
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        word_d    = word_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    beat_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    result_d = final_word;
                    state_d  = ST_DONE;
                end else begin
                    result_d = merged;
                    beat_d   = beat_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            word_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            word_q   <= word_d;
            result_q <= result_d;
        end
    end

    assign out_data = result_q;

endmodule

// File: tb/tb_des_sbox_engine.sv
module tb_des_sbox_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:48] in_data  [4];
    logic [1:32] out_data [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Instances: g0 LANES=8, g1 LANES=2, g2 LANES=1, g3 LANES=4.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 1 : 4;
        des_sbox_engine #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    // Independent reference copy of the FIPS 46-3 S-boxes: entry box*4+row, column 0 in the top nibble.
    localparam logic [0:31][63:0] TB_S = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    localparam int TB_P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

`ifdef DES_SBOX_PPERM_EN
    localparam logic [1:32] EXP_ZERO = 32'hD8D8DBBC;
`else
    localparam logic [1:32] EXP_ZERO = 32'hEFA72C4D;
`endif

    function automatic logic [1:32] model_s(input logic [1:48] d);
        logic [1:32] r;
        logic [5:0]  c;
        logic [1:0]  row;
        logic [3:0]  col;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            c   = d[6*b+1 +: 6];
            row = {c[5], c[0]};
            col = c[4:1];
            r[4*b+1 +: 4] = TB_S[b*4 + int'(row)][63 - 4*int'(col) -: 4];
        end
        return r;
    endfunction

    function automatic logic [1:32] model_p(input logic [1:32] x);
        logic [1:32] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[i+1] = x[TB_P[i]];
        return y;
    endfunction

    function automatic logic [1:32] expect_of(input logic [1:32] raw);
`ifdef DES_SBOX_PPERM_EN
        return model_p(raw);
`else
        return raw;
`endif
    endfunction

    function automatic int beats_of(input int g);
        case (g)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int g, input logic [1:48] d);
        @(negedge clk);
        in_data[g]  = d;
        in_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    // Counts cycles until out_valid; in_ready must stay low and busy high meanwhile.
    task automatic wait_done(input int g, output int lat, output bit hs_ok);
        lat   = 0;
        hs_ok = 1'b1;
        while (out_valid[g] !== 1'b1 && lat < 40) begin
            if (in_ready[g] !== 1'b0 || busy[g] !== 1'b1) hs_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready[g] !== 1'b0) hs_ok = 1'b0;
    endtask

    task automatic release_out(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[g] = 1'b0;
    endtask

    task automatic run_word(input int g, input logic [1:48] d, input logic [1:32] exp, input string tag);
        int lat;
        bit ok;
        start(g, d);
        wait_done(g, lat, ok);
        check({tag, "_latency"}, 64'(lat), 64'(beats_of(g)));
        check({tag, "_handshake"}, 64'(ok), 64'd1);
        check({tag, "_data"}, 64'(out_data[g]), 64'(exp));
        release_out(g);
        check({tag, "_ready_after"}, 64'(in_ready[g]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  ok;
        bit  bp_ok;
        logic [1:48] w;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int g = 0; g < 4; g++) in_data[g] = '0;
        #12;
        for (int g = 0; g < 4; g++) begin
            check("reset_in_ready",  64'(in_ready[g]),  64'd1);
            check("reset_out_valid", 64'(out_valid[g]), 64'd0);
            check("reset_out_data",  64'(out_data[g]),  64'd0);
            check("reset_busy",      64'(busy[g]),      64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // out_ready with nothing pending must not produce a result.
        out_ready = 4'hF;
        @(posedge clk);
        #1;
        check("stray_out_ready", 64'(out_valid), 64'd0);
        out_ready = '0;

        run_word(0, 48'h0, EXP_ZERO, "l8_zero");
        run_word(1, {48{1'b1}}, expect_of(32'hD9CE3DCB), "l2_ones");
        run_word(3, 48'h0, EXP_ZERO, "l4_zero");

        // Every chunk value replicated across all eight boxes.
        for (int v = 0; v < 64; v++) begin
            w = {8{6'(v)}};
            run_word(2, w, expect_of(model_s(w)), "l1_sweep");
`ifndef DES_SBOX_PPERM_EN
            if (v == 0)  check("s2_chunk00", 64'(out_data[2][5:8]), 64'd15);
            if (v == 63) check("s2_chunk3f", 64'(out_data[2][5:8]), 64'd9);
`endif
        end

        // Backpressure: result held for 10 cycles while a second word waits.
        start(0, 48'h0);
        wait_done(0, lat, ok);
        check("bp_latency", 64'(lat), 64'd1);
        in_data[0]  = {48{1'b1}};
        in_valid[0] = 1'b1;
        bp_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== EXP_ZERO) bp_ok = 1'b0;
        end
        check("bp_hold", 64'(bp_ok), 64'd1);
        check("bp_data", 64'(out_data[0]), 64'(EXP_ZERO));
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("bp_release_valid", 64'(out_valid[0]), 64'd0);
        check("bp_release_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("bp_second_accept", 64'(busy[0]), 64'd1);
        wait_done(0, lat, ok);
        check("bp_second_data", 64'(out_data[0]), 64'(expect_of(32'hD9CE3DCB)));
        release_out(0);

        // Reset while the LANES=1 engine sits in beat 3.
        start(2, {48{1'b1}});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid[2]), 64'd0);
        check("midrst_out_data",  64'(out_data[2]),  64'd0);
        check("midrst_in_ready",  64'(in_ready[2]),  64'd1);
        check("midrst_busy",      64'(busy[2]),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        w = 48'h0123456789AB;
        run_word(2, w, expect_of(model_s(w)), "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
